// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and constants for prog_loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERROR} loader_state_e;
  localparam int LOADER_LEN_ZERO = 0;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams a length header plus words into the instruction bank, holding the core in reset until done
// Ports: clk/rst (sync, active-high); i_start session pulse; i_valid/i_data/o_ready stream handshake;
// o_write_enable/o_write_select/o_write_data bank write port; o_core_rst core reset; o_busy; o_error.
// Optional: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum word before DONE.
module prog_loader
  import loader_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_INSTR = 10,
  localparam int INSTR_SELECT = $clog2(NUM_INSTR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_valid,
  input  logic [REG_WIDTH-1:0]    i_data,
  output logic                    o_ready,
  output logic                    o_write_enable,
  output logic [INSTR_SELECT-1:0] o_write_select,
  output logic [REG_WIDTH-1:0]    o_write_data,
  output logic                    o_core_rst,
  output logic                    o_busy,
  output logic                    o_error
);
  localparam int LW = INSTR_SELECT + 1;
  loader_state_e state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [INSTR_SELECT-1:0] addr_q, addr_d, sel_q, sel_d;
  logic [REG_WIDTH-1:0] data_q, data_d;
  logic we_q, we_d, core_rst_q;
  logic acc, bad_len, last;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [REG_WIDTH-1:0] csum_q, csum_d;
`endif
  assign o_ready = state_q == HDR || state_q == DATA || state_q == CHK;
  assign o_busy = o_ready;
  assign o_error = state_q == ERROR;
  assign o_write_enable = we_q;
  assign o_write_select = sel_q;
  assign o_write_data = data_q;
  assign o_core_rst = core_rst_q;
  assign acc = i_valid & o_ready;
  assign bad_len = i_data == REG_WIDTH'(LOADER_LEN_ZERO) || i_data > REG_WIDTH'(NUM_INSTR);
  assign last = LW'(addr_q) + LW'(1) == len_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    addr_d = addr_q;
    we_d = 1'b0;
    sel_d = sel_q;
    data_d = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: state_d = i_start ? HDR : state_q;
      HDR: if (acc) begin
        state_d = bad_len ? ERROR : DATA;
        len_d = bad_len ? len_q : i_data[LW-1:0];
        addr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d = '0;
`endif
      end
      DATA: if (acc) begin
        we_d = 1'b1;
        sel_d = addr_q;
        data_d = i_data;
        addr_d = last ? addr_q : addr_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ i_data;
        state_d = last ? CHK : DATA;
`else
        state_d = last ? DONE : DATA;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: if (acc) state_d = i_data == csum_q ? DONE : ERROR;
`endif
      default: state_d = IDLE;
    endcase
  end
  // core_rst follows DONE one cycle late so the final write lands before the core fetches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      data_q <= '0;
      core_rst_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      addr_q <= addr_d;
      we_q <= we_d;
      sel_q <= sel_d;
      data_q <= data_d;
      core_rst_q <= state_q != DONE;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader write stream and control outputs
module tb_prog_loader;
  localparam int RW = 32;
  localparam int NI = 10;
  localparam int IS = $clog2(NI);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic i_valid = 1'b0;
  logic [RW-1:0] i_data = '0;
  logic o_ready, o_write_enable, o_core_rst, o_busy, o_error;
  logic [IS-1:0] o_write_select;
  logic [RW-1:0] o_write_data;
  typedef struct {
    int sel;
    logic [RW-1:0] data;
    int at;
  } wr_t;
  wr_t q[$];
  logic [RW-1:0] mem[NI];
  logic [RW-1:0] words[NI];
  int cmp = 0;
  int mis = 0;
  int cyc = 0;
  prog_loader #(.REG_WIDTH(RW), .NUM_INSTR(NI)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_write_enable(o_write_enable), .o_write_select(o_write_select),
    .o_write_data(o_write_data), .o_core_rst(o_core_rst), .o_busy(o_busy), .o_error(o_error)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (o_write_enable === 1'b1) mem[o_write_select] <= o_write_data;
  end
  initial forever begin
    @(negedge clk);
    if (o_write_enable === 1'b1) begin
      cmp++;
      if (q.size() == 0) begin
        mis++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", o_write_select, o_write_data);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (int'(o_write_select) != e.sel || o_write_data !== e.data || cyc != e.at) begin
          mis++;
          $display("FAIL write: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                   o_write_select, o_write_data, cyc, e.sel, e.data, e.at);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string n, input logic [RW-1:0] a, input logic [RW-1:0] e);
    cmp++;
    if (a !== e) begin
      mis++;
      $display("FAIL %s: got %h, required %h", n, a, e);
    end
  endtask
  task automatic start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask
  task automatic xfer(input logic [RW-1:0] w, input int gap, input bit dat, input int a);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("ready_in_gap", {31'b0, o_ready}, 1);
    end
    i_valid = 1'b1;
    i_data = w;
    t = 0;
    while (o_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (o_ready !== 1'b1) begin
      cmp++;
      mis++;
      $display("FAIL accept_timeout: got ready %b, required 1 within 20 cycles", o_ready);
    end else if (dat) q.push_back('{a, w, cyc + 1});
    @(negedge clk);
    i_valid = 1'b0;
    i_data = '0;
  endtask
  task automatic session(input int len, input int gap);
    logic [RW-1:0] x;
    x = '0;
    xfer(RW'(len), 0, 1'b0, 0);
    for (int i = 0; i < len; i++) begin
      xfer(words[i], gap, 1'b1, i);
      x ^= words[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    xfer(x, 0, 1'b0, 0);
`endif
  endtask
  task automatic done_chk(input string n);
    chk({n, "_busy_off"}, {31'b0, o_busy}, 0);
    chk({n, "_core_rst_held"}, {31'b0, o_core_rst}, 1);
    @(negedge clk);
    chk({n, "_core_rst_drop"}, {31'b0, o_core_rst}, 0);
    chk({n, "_no_error"}, {31'b0, o_error}, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, o_ready}, 0);
    chk("rst_we", {31'b0, o_write_enable}, 0);
    chk("rst_sel", RW'(o_write_select), 0);
    chk("rst_data", o_write_data, 0);
    chk("rst_core_rst", {31'b0, o_core_rst}, 1);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_error", {31'b0, o_error}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_core_rst", {31'b0, o_core_rst}, 1);
    // back-to-back stream
    start();
    chk("hdr_busy", {31'b0, o_busy}, 1);
    chk("hdr_ready", {31'b0, o_ready}, 1);
    words[0] = 32'hA0A0_0001;
    words[1] = 32'hB0B0_0002;
    words[2] = 32'hC0C0_0003;
    session(3, 0);
    done_chk("t1");
    // gapped stream
    start();
    words[0] = 32'h1234_5678;
    words[1] = 32'h8765_4321;
    session(2, 2);
    done_chk("t2");
    // bad lengths
    start();
    xfer(0, 0, 1'b0, 0);
    chk("len0_error", {31'b0, o_error}, 1);
    chk("len0_core_rst", {31'b0, o_core_rst}, 1);
    chk("len0_ready", {31'b0, o_ready}, 0);
    @(negedge clk);
    chk("len0_error_sticky", {31'b0, o_error}, 1);
    start();
    chk("restart_clears_error", {31'b0, o_error}, 0);
    chk("restart_busy", {31'b0, o_busy}, 1);
    xfer(11, 0, 1'b0, 0);
    chk("len11_error", {31'b0, o_error}, 1);
    chk("len11_core_rst", {31'b0, o_core_rst}, 1);
    start();
    chk("restart2_clears_error", {31'b0, o_error}, 0);
    // full depth, then a short rewrite
    for (int i = 0; i < NI; i++) words[i] = 32'h100 + i;
    session(NI, 0);
    done_chk("t4");
    chk("t4_mem9", mem[9], 32'h109);
    start();
    chk("t4b_busy", {31'b0, o_busy}, 1);
    @(negedge clk);
    chk("t4b_core_rst_reassert", {31'b0, o_core_rst}, 1);
    words[0] = 32'h0000_0ABC;
    session(1, 0);
    done_chk("t4b");
    chk("t4b_mem0", mem[0], 32'hABC);
    chk("t4b_mem1_kept", mem[1], 32'h101);
    // reset mid-session
    start();
    xfer(4, 0, 1'b0, 0);
    xfer(32'hD00D_0000, 0, 1'b1, 0);
    xfer(32'hD00D_0001, 0, 1'b1, 1);
    rst = 1'b1;
    i_valid = 1'b1;
    i_data = 32'hD00D_0002;
    @(negedge clk);
    chk("abort_we", {31'b0, o_write_enable}, 0);
    chk("abort_core_rst", {31'b0, o_core_rst}, 1);
    chk("abort_busy", {31'b0, o_busy}, 0);
    chk("abort_ready", {31'b0, o_ready}, 0);
    chk("abort_sel", RW'(o_write_select), 0);
    rst = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", {31'b0, o_busy}, 0);
    chk("abort_mem0", mem[0], 32'hD00D_0000);
    chk("abort_mem1", mem[1], 32'hD00D_0001);
`ifdef PROG_LOADER_CHECKSUM_EN
    start();
    xfer(2, 0, 1'b0, 0);
    xfer(5, 0, 1'b1, 0);
    xfer(3, 0, 1'b1, 1);
    chk("chk_busy", {31'b0, o_busy}, 1);
    xfer(6, 0, 1'b0, 0);
    done_chk("csum_ok");
    start();
    xfer(2, 0, 1'b0, 0);
    xfer(5, 0, 1'b1, 0);
    xfer(3, 0, 1'b1, 1);
    xfer(7, 0, 1'b0, 0);
    chk("csum_bad_error", {31'b0, o_error}, 1);
    chk("csum_bad_core_rst", {31'b0, o_core_rst}, 1);
    @(negedge clk);
    chk("csum_bad_core_rst_held", {31'b0, o_core_rst}, 1);
`endif
    repeat (2) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
